// File: rtl/mmio_pkg.sv
// mmio_pkg
// Shared definitions for the MMIO arbiter slice: bus widths, the default
// read data returned by a watchdog-terminated access, and the arbiter FSM
// state encoding.
package mmio_pkg;

    localparam int MMIO_ADDR_W = 32;
    localparam int MMIO_DATA_W = 32;

    localparam logic [MMIO_DATA_W-1:0] MMIO_TIMEOUT_RDATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mmio_arbiter_if.sv
// mmio_arbiter_if
// Bundles every handshake/bus signal around the arbiter:
//   req0_* / req1_*  : requester ports (read/write levels, addr, wdata in;
//                      done pulse and rdata out)
//   mmio_*           : downstream device port (read/write levels, addr,
//                      write data out; done and read data in)
//   bus_err          : pulse alongside the done of a watchdog-terminated access
// Modport slave is the arbiter's view, modport master the surrounding
// requesters + device.
interface mmio_arbiter_if;
    import mmio_pkg::*;

    logic                   req0_read;
    logic                   req0_write;
    logic [MMIO_ADDR_W-1:0] req0_addr;
    logic [MMIO_DATA_W-1:0] req0_wdata;
    logic                   req0_done;
    logic [MMIO_DATA_W-1:0] req0_rdata;

    logic                   req1_read;
    logic                   req1_write;
    logic [MMIO_ADDR_W-1:0] req1_addr;
    logic [MMIO_DATA_W-1:0] req1_wdata;
    logic                   req1_done;
    logic [MMIO_DATA_W-1:0] req1_rdata;

    logic                   mmio_read;
    logic                   mmio_write;
    logic [MMIO_ADDR_W-1:0] mmio_addr;
    logic [MMIO_DATA_W-1:0] mmio_write_data;
    logic                   mmio_done;
    logic [MMIO_DATA_W-1:0] mmio_read_data;

    logic                   bus_err;

    modport slave (
        input  req0_read, req0_write, req0_addr, req0_wdata,
        output req0_done, req0_rdata,
        input  req1_read, req1_write, req1_addr, req1_wdata,
        output req1_done, req1_rdata,
        output mmio_read, mmio_write, mmio_addr, mmio_write_data,
        input  mmio_done, mmio_read_data,
        output bus_err
    );

    modport master (
        output req0_read, req0_write, req0_addr, req0_wdata,
        input  req0_done, req0_rdata,
        output req1_read, req1_write, req1_addr, req1_wdata,
        input  req1_done, req1_rdata,
        input  mmio_read, mmio_write, mmio_addr, mmio_write_data,
        output mmio_done, mmio_read_data,
        input  bus_err
    );

endinterface

// File: rtl/mmio_rr_pick.sv
// mmio_rr_pick
// Combinational two-way round-robin selector.
//   valid0, valid1 : pending requests
//   last_grant     : port granted most recently
//   grant          : at least one request is pending
//   grant_idx      : winning port (a lone requester wins outright; on a tie
//                    the port that was not granted last wins)
module mmio_rr_pick (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant,
    output logic grant_idx
);

    assign grant     = valid0 | valid1;
    assign grant_idx = (valid0 & valid1) ? ~last_grant : valid1;

endmodule

// File: rtl/mmio_arbiter.sv
// mmio_arbiter
// Shares one MMIO device port between port 0 (instruction fetch) and
// port 1 (data load/store). One transaction at a time: the winner's op,
// address and write data are latched at grant and driven downstream until
// the device reports done; the owner then gets a one-cycle done pulse with
// the captured read data.
// Ports:
//   sys_clk : system clock, rising edge
//   rst     : asynchronous active-high reset
//   bus     : mmio_arbiter_if.slave (requester ports, device port, bus_err)
// Build option: MMIO_ARB_TIMEOUT_EN adds a watchdog that force-completes an
// access after TIMEOUT_CYCLES BUSY cycles with read data TIMEOUT_RDATA and
// a bus_err pulse. Without it bus_err is tied 0 and a device that never
// answers stalls the arbiter in BUSY.
//
// state | meaning
// IDLE  | no transaction, arbitrate pending requests
// BUSY  | latched request driven downstream, waiting for mmio_done
// RESP  | downstream idle, owner sees done + rdata for this cycle only
module mmio_arbiter
    import mmio_pkg::*;
#(
    parameter int unsigned            TIMEOUT_CYCLES = 256,
    parameter logic [MMIO_DATA_W-1:0] TIMEOUT_RDATA  = MMIO_TIMEOUT_RDATA_DEF
) (
    input  logic           sys_clk,
    input  logic           rst,
    mmio_arbiter_if.slave  bus
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("mmio_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t             state_q;
    arb_state_t             state_d;
    logic                   owner_q;
    logic                   last_grant_q;
    logic                   write_q;
    logic [MMIO_ADDR_W-1:0] addr_q;
    logic [MMIO_DATA_W-1:0] wdata_q;
    logic [MMIO_DATA_W-1:0] rdata_q;

    logic valid0;
    logic valid1;
    logic pick_grant;
    logic pick_idx;
    logic grant_load;
    logic busy_exit;
    logic timeout_hit;
    logic in_busy;
    logic in_resp;

    // Read+write together is treated as a write, so only the write level
    // is latched as the op.
    assign valid0 = bus.req0_read | bus.req0_write;
    assign valid1 = bus.req1_read | bus.req1_write;

    mmio_rr_pick u_pick (
        .valid0     (valid0),
        .valid1     (valid1),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .grant_idx  (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        grant_load = 1'b0;
        busy_exit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_grant) begin
                    grant_load = 1'b1;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (bus.mmio_done || timeout_hit) begin
                    busy_exit = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            if (grant_load) begin
                owner_q      <= pick_idx;
                last_grant_q <= pick_idx;
                if (pick_idx) begin
                    write_q <= bus.req1_write;
                    addr_q  <= bus.req1_addr;
                    wdata_q <= bus.req1_wdata;
                end else begin
                    write_q <= bus.req0_write;
                    addr_q  <= bus.req0_addr;
                    wdata_q <= bus.req0_wdata;
                end
            end
            // A real done beats the watchdog when both land in one cycle.
            if (busy_exit) begin
                if (bus.mmio_done) begin
                    rdata_q <= write_q ? '0 : bus.mmio_read_data;
                end else begin
                    rdata_q <= TIMEOUT_RDATA;
                end
            end
        end
    end

`ifdef MMIO_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] to_cnt_q;
    logic             err_q;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (grant_load) begin
                to_cnt_q <= '0;
            end else if (in_busy) begin
                to_cnt_q <= to_cnt_q + CNT_W'(1);
            end
            if (busy_exit) begin
                err_q <= ~bus.mmio_done;
            end
        end
    end

    assign timeout_hit = in_busy && (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.bus_err = in_resp & err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.bus_err = 1'b0;
`endif

    assign in_busy = (state_q == BUSY);
    assign in_resp = (state_q == RESP);

    assign bus.mmio_read       = in_busy & ~write_q;
    assign bus.mmio_write      = in_busy &  write_q;
    assign bus.mmio_addr       = in_busy ? addr_q  : '0;
    assign bus.mmio_write_data = in_busy ? wdata_q : '0;

    assign bus.req0_done  = in_resp & ~owner_q;
    assign bus.req1_done  = in_resp &  owner_q;
    assign bus.req0_rdata = (in_resp & ~owner_q) ? rdata_q : '0;
    assign bus.req1_rdata = (in_resp &  owner_q) ? rdata_q : '0;

endmodule

// File: tb/tb_mmio_arbiter.sv
module tb_mmio_arbiter;
    import mmio_pkg::*;

    localparam int TO = 8;

    logic clk;
    logic rst;

    mmio_arbiter_if bus ();

    mmio_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_RDATA  (32'hDEAD_BEEF)
    ) dut (
        .sys_clk (clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // requester side of the model
    bit          pend [2];
    bit          p_rd [2];
    bit          p_wr [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wdata [2];
    bit          drv_v [2];
    int          done_cnt [2];
    int          busy_len [2];
    int          agent_mode = 0;     // 0 directed, 1 random, 2 continuous writes

    // device side of the model
    bit          dev_act = 0;
    int          dev_port;
    bit          dev_wr;
    logic [31:0] dev_addr;
    logic [31:0] dev_wdata;
    int          dev_left;
    int          dev_cyc;
    int          dev_wait_cfg = -2;  // -2 random, -1 never answers, >=0 fixed wait
    bit          dev_fix = 0;
    logic [31:0] dev_fix_data;

    // expected response for the coming cycle
    bit          resp_due = 0;
    int          resp_port;
    logic [31:0] resp_data;
    bit          resp_err;

    int          model_last = 1;
    int          served_q [$];
    int          cyc = 0;
    logic [31:0] obs_rdata;
    logic        obs_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.req0_read  = pend[0] & p_rd[0];
        bus.req0_write = pend[0] & p_wr[0];
        bus.req0_addr  = p_addr[0];
        bus.req0_wdata = p_wdata[0];
        bus.req1_read  = pend[1] & p_rd[1];
        bus.req1_write = pend[1] & p_wr[1];
        bus.req1_addr  = p_addr[1];
        bus.req1_wdata = p_wdata[1];
        for (int p = 0; p < 2; p++) drv_v[p] = pend[p] & (p_rd[p] | p_wr[p]);
    endtask

    task automatic issue(input int p, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
        pend[p]    = 1'b1;
        p_rd[p]    = rd;
        p_wr[p]    = wr;
        p_addr[p]  = a;
        p_wdata[p] = d;
        drive();
    endtask

    // One clock cycle: check outputs against the model, play the device,
    // then let the requesters react.
    task automatic step();
        logic        act;
        int          seen;
        int          exp_port;
        logic [31:0] rd_val;
        int          r;
        @(posedge clk);
        #1;
        cyc++;
        check_eq("done0", bus.req0_done, resp_due && resp_port == 0);
        check_eq("done1", bus.req1_done, resp_due && resp_port == 1);
        check_eq("rdata0", bus.req0_rdata, (resp_due && resp_port == 0) ? resp_data : 32'h0);
        check_eq("rdata1", bus.req1_rdata, (resp_due && resp_port == 1) ? resp_data : 32'h0);
        check_eq("bus_err", bus.bus_err, resp_due && resp_err);
        if (resp_due) begin
            obs_rdata = (resp_port == 0) ? bus.req0_rdata : bus.req1_rdata;
            obs_err   = bus.bus_err;
            pend[resp_port] = 1'b0;
            done_cnt[resp_port]++;
        end
        resp_due = 1'b0;

        act = bus.mmio_read | bus.mmio_write;
        if (act && !dev_act) begin
            if (pend[0] && bus.mmio_addr == p_addr[0])      seen = 0;
            else if (pend[1] && bus.mmio_addr == p_addr[1]) seen = 1;
            else                                            seen = 2;
            if (drv_v[0] && drv_v[1]) exp_port = 1 - model_last;
            else if (drv_v[0])        exp_port = 0;
            else if (drv_v[1])        exp_port = 1;
            else                      exp_port = 3;
            check_eq("grant", seen, exp_port);
            if (seen < 2) begin
                check_eq("mmio_wr", bus.mmio_write, p_wr[seen]);
                check_eq("mmio_rd", bus.mmio_read, p_rd[seen] & ~p_wr[seen]);
                if (p_wr[seen]) check_eq("mmio_wdata", bus.mmio_write_data, p_wdata[seen]);
                model_last = seen;
                served_q.push_back(seen);
            end
            dev_act   = 1'b1;
            dev_port  = seen;
            dev_wr    = bus.mmio_write;
            dev_addr  = bus.mmio_addr;
            dev_wdata = bus.mmio_write_data;
            dev_left  = (dev_wait_cfg == -2) ? int'($urandom_range(0, 4)) : dev_wait_cfg;
            dev_cyc   = 0;
        end else if (act && dev_act) begin
            check_eq("hold_addr", bus.mmio_addr, dev_addr);
            check_eq("hold_wr", bus.mmio_write, dev_wr);
            check_eq("hold_wdata", bus.mmio_write_data, dev_wdata);
        end else if (!act && dev_act) begin
            check_eq("mmio_drop", act, 1);
            dev_act = 1'b0;
        end

        if (dev_act) begin
            dev_cyc++;
            rd_val = dev_fix ? dev_fix_data : $urandom;
            if (dev_left == 0) begin
                bus.mmio_done      = 1'b1;
                bus.mmio_read_data = rd_val;
                resp_due  = 1'b1;
                resp_port = dev_port;
                resp_data = dev_wr ? 32'h0 : rd_val;
                resp_err  = 1'b0;
                if (dev_port < 2) busy_len[dev_port] = dev_cyc;
                dev_act = 1'b0;
            end else begin
                bus.mmio_done      = 1'b0;
                bus.mmio_read_data = $urandom;
                if (dev_left > 0) dev_left--;
`ifdef MMIO_ARB_TIMEOUT_EN
                if (dev_cyc == TO) begin
                    resp_due  = 1'b1;
                    resp_port = dev_port;
                    resp_data = 32'hDEAD_BEEF;
                    resp_err  = 1'b1;
                    dev_act   = 1'b0;
                end
`endif
            end
        end else begin
            bus.mmio_done      = 1'b0;
            bus.mmio_read_data = 32'h0;
        end

        for (int p = 0; p < 2; p++) begin
            if (!pend[p]) begin
                if (agent_mode == 1 && $urandom_range(0, 2) == 0) begin
                    r = int'($urandom_range(0, 3));
                    issue(p, r != 2, r >= 2, ($urandom & ~32'h30) | (p != 0 ? 32'h20 : 32'h10), $urandom);
                end else if (agent_mode == 2) begin
                    issue(p, 1'b0, 1'b1, p != 0 ? 32'h20 : 32'h10, p != 0 ? 32'hBBBB_0001 : 32'hAAAA_0000);
                end
            end
        end
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        drive();
        dev_act  = 1'b0;
        resp_due = 1'b0;
        model_last = 1;
        served_q.delete();
        bus.mmio_done      = 1'b0;
        bus.mmio_read_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd"},    bus.mmio_read, 0);
        check_eq({tag, "_wr"},    bus.mmio_write, 0);
        check_eq({tag, "_addr"},  bus.mmio_addr, 0);
        check_eq({tag, "_wdata"}, bus.mmio_write_data, 0);
        check_eq({tag, "_done0"}, bus.req0_done, 0);
        check_eq({tag, "_done1"}, bus.req1_done, 0);
        check_eq({tag, "_rdat0"}, bus.req0_rdata, 0);
        check_eq({tag, "_rdat1"}, bus.req1_rdata, 0);
        check_eq({tag, "_err"},   bus.bus_err, 0);
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max && (pend[0] || pend[1] || dev_act || resp_due); i++) step();
        check_eq("idle_bound", pend[0] | pend[1] | dev_act | resp_due, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "time limit");
    end

    initial begin
        int start;
        int d0;
        int d1;
        int base;

        rst = 1'b0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; p_rd[p] = 0; p_wr[p] = 0; p_addr[p] = 0; p_wdata[p] = 0;
            done_cnt[p] = 0; busy_len[p] = 0;
        end
        drive();
        bus.mmio_done      = 1'b0;
        bus.mmio_read_data = 32'h0;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst");
        do_reset();
        check_all_zero("post_rst");

        // single read, zero-wait device
        dev_wait_cfg = 0;
        dev_fix = 1'b1;
        dev_fix_data = 32'h0000_00A5;
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        issue(0, 1'b1, 1'b0, 32'hFFFF_FC00, 32'h0);
        start = cyc;
        for (int i = 0; i < 10 && done_cnt[0] == d0; i++) step();
        check_eq("rd_latency", cyc - start, 2);
        check_eq("rd_data", obs_rdata, 32'h0000_00A5);
        check_eq("rd_no_done1", done_cnt[1] - d1, 0);
        dev_fix = 1'b0;
        wait_idle(10);

        // continuous contention after reset: strict alternation from port 0
        do_reset();
        agent_mode = 2;
        for (int i = 0; i < 40 && served_q.size() < 4; i++) step();
        agent_mode = 0;
        check_eq("order_cnt", served_q.size() >= 4, 1);
        for (int i = 0; i < 4 && i < served_q.size(); i++)
            check_eq($sformatf("order%0d", i), served_q[i], i % 2);
        wait_idle(40);

        // wait states with a late port-1 request
        dev_wait_cfg = 5;
        base = served_q.size();
        issue(0, 1'b0, 1'b1, 32'h0000_0100, 32'h5555_AAAA);
        step();
        step();
        issue(1, 1'b1, 1'b0, 32'h0000_0220, 32'h0);
        wait_idle(60);
        check_eq("ws_busy0", busy_len[0], 6);
        check_eq("ws_busy1", busy_len[1], 6);
        check_eq("ws_cnt", served_q.size() - base, 2);
        if (served_q.size() >= base + 2) begin
            check_eq("ws_first", served_q[base], 0);
            check_eq("ws_second", served_q[base + 1], 1);
        end

        // read+write together on port 1 behaves as a write
        dev_wait_cfg = 0;
        base = served_q.size();
        issue(1, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_1234);
        for (int i = 0; i < 6 && served_q.size() == base; i++) step();
        check_eq("rw_write", bus.mmio_write, 1);
        check_eq("rw_read", bus.mmio_read, 0);
        check_eq("rw_wdata", bus.mmio_write_data, 32'h0000_1234);
        wait_idle(10);

        // reset while BUSY
        dev_wait_cfg = -1;
        issue(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
        step();
        step();
        step();
        check_eq("mid_busy", bus.mmio_read, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        do_reset();
        dev_wait_cfg = 0;
        d0 = done_cnt[0];
        repeat (3) step();
        check_eq("rst_no_done", done_cnt[0] - d0, 0);
        issue(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        issue(1, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
        step();
        check_eq("rst_tie_cnt", served_q.size(), 1);
        if (served_q.size() >= 1) check_eq("rst_tie_port0", served_q[0], 0);
        wait_idle(20);

`ifdef MMIO_ARB_TIMEOUT_EN
        // watchdog: device never answers
        do_reset();
        dev_wait_cfg = -1;
        d0 = done_cnt[0];
        issue(0, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
        start = cyc;
        for (int i = 0; i < 30 && done_cnt[0] == d0; i++) step();
        check_eq("to_latency", cyc - start, TO + 1);
        check_eq("to_rdata", obs_rdata, 32'hDEAD_BEEF);
        check_eq("to_err", obs_err, 1);
        wait_idle(10);
        // done on the last allowed cycle wins over the watchdog
        dev_wait_cfg = TO - 1;
        dev_fix = 1'b1;
        dev_fix_data = 32'h0000_0077;
        d0 = done_cnt[0];
        issue(0, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
        for (int i = 0; i < 30 && done_cnt[0] == d0; i++) step();
        check_eq("edge_err", obs_err, 0);
        check_eq("edge_rdata", obs_rdata, 32'h0000_0077);
        dev_fix = 1'b0;
        wait_idle(10);
`endif

        // random traffic against the model
        do_reset();
        dev_wait_cfg = -2;
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        agent_mode = 1;
        repeat (3000) step();
        agent_mode = 0;
        wait_idle(200);
        check_eq("rand_served0", (done_cnt[0] - d0) > 10, 1);
        check_eq("rand_served1", (done_cnt[1] - d1) > 10, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_arbiter.md
Name: mmio_arbiter

Overview:
Shares the single MMIO device port (switches, ROM, LEDs behind the MMIO decoder) between two requesters: port 0 (instruction-side/ROM fetch) and port 1 (data-side load/store). It holds one transaction at a time and latches address and data at grant. It drives the downstream read/write level until the device returns done, then returns a one-cycle done pulse with the read data to the owner. Round-robin arbitration; an optional watchdog terminates hung accesses.

Parameters:
TIMEOUT_CYCLES, 256, cycles in BUSY without downstream done before forced completion (used only with MMIO_ARB_TIMEOUT_EN)
TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on a timed-out access

Ports:
sys_clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req0_read / req0_write  in  1 / 1  port-0 request levels
req0_addr / req0_wdata  in  32 / 32  port-0 address and write data
req0_done  out  1  port-0 completion pulse
req0_rdata  out  32  port-0 read data, valid while req0_done=1
req1_read, req1_write, req1_addr, req1_wdata, req1_done, req1_rdata: same as port 0, for port 1
mmio_read / mmio_write  out  1 / 1  downstream request levels
mmio_addr / mmio_write_data  out  32 / 32  downstream address and write data
mmio_done  in  1  downstream completion (combinational from the devices)
mmio_read_data  in  32  downstream read data
bus_err  out  1  one-cycle pulse with the done of a timed-out access; constant 0 without the macro

Behaviour:
- Reset values: all outputs 0; state=IDLE; last_grant=1, so port 0 wins the first tie.
- Request: reqN_valid = reqN_read | reqN_write. Read and write both high is illegal; it is treated as a write.
- Request hold: a requester holds its request, address and data stable until it samples reqN_done=1. It deasserts at that same edge.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Neither request valid: stay in IDLE.
  - One request valid: grant that port.
  - Both valid: grant the port != last_grant.
  - On grant: latch owner, op, addr and wdata into registers; update last_grant; go to BUSY.
- BUSY:
  - mmio_read/mmio_write/mmio_addr/mmio_write_data are driven from the latched registers. Outputs are registered, so downstream sees the request the cycle after grant.
  - When mmio_done=1: capture mmio_read_data, go to RESP.
  - Writes capture 0 as read data.
- RESP:
  - Downstream request is 0, giving the device one idle cycle.
  - Owner's reqN_done=1 and reqN_rdata=captured data for exactly this cycle.
  - The other port's done and rdata are 0.
  - Next state is IDLE.
- Latency: request high in cycle T (IDLE) gives downstream request in T+1. Done in cycle D gives reqN_done in D+1. A zero-wait device (done same cycle) completes in 3 cycles total. Minimum issue interval is 3 cycles.
- Non-owner requests during BUSY/RESP wait; no starvation (round-robin alternates under continuous contention).
- Owner dropping its request mid-BUSY is ignored; the latched transaction completes.
- Reset mid-operation: immediate IDLE, all outputs 0, transaction dropped with no done pulse.
- Without the watchdog, an unmapped address (mmio_done never 1) stalls BUSY forever.

Optional Feature:
- Macro: MMIO_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES-1 with mmio_done=0: go to RESP with rdata=TIMEOUT_RDATA, and pulse bus_err with reqN_done.
  - mmio_done in that same cycle wins (normal completion, no error).
  - Counter width is $clog2(TIMEOUT_CYCLES)+1.
- Undefined: no counter, bus_err tied 0, behaviour as above.

Decomposition:
- Shared package mmio_pkg: FSM state enum (IDLE/BUSY/RESP), MMIO address width 32, data width 32, default TIMEOUT_RDATA.
- One sub-module: mmio_rr_pick, the combinational 2-way round-robin selector (valid0, valid1, last_grant -> grant, grant_idx). Everything else stays in mmio_arbiter.

Test Plan:
- Single read: port 0 reads 0xFFFF_FC00, device done in 1st BUSY cycle with 0x0000_00A5 -> req0_done one cycle with req0_rdata=0x0000_00A5, 3 cycles total; req1_done stays 0.
- Contention: both ports request writes simultaneously and continuously, addr0=0x...10, addr1=0x...20 -> downstream order port0, port1, port0, port1; each done pulses once per transaction.
- Wait states: device holds done low 5 cycles -> mmio_write held with stable addr/data for 5 cycles; port1 request arriving mid-BUSY is served only after RESP.
- Reset mid-BUSY: assert rst during BUSY -> all outputs 0 asynchronously, no reqN_done; after release, port 0 wins the first tie.
- Timeout (macro on, TIMEOUT_CYCLES=8): read with done never asserted -> reqN_done, rdata=0xDEAD_BEEF and bus_err=1 in the same cycle, 8 BUSY cycles after grant.
- Read+write both high on port 1 with wdata=0x1234 -> downstream mmio_write=1, mmio_read=0, wdata=0x1234.
